// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one 32-bit asynchronous SRAM between instruction fetch
//            and data loads/stores (LW, LB, SW, SB). Data requests win over
//            fetch; an FSM sequences ce_n/oe_n/we_n and returns read data.
// Ports    : clk, rst (async, active-low)
//            if_req/if_addr -> if_data/if_valid/if_stall      (fetch side)
//            mem_read/mem_write/load_byte/mem_addr/mem_wdata
//                          -> mem_rdata/mem_done/mem_stall    (data side)
//            ram_addr/ram_dq_o/ram_dq_oe/ram_dq_i/ram_be_n/
//            ram_ce_n/ram_oe_n/ram_we_n                       (SRAM pins)
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int RD_WAIT  = 1,
  parameter int WE_WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              load_byte,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_dq_o,
  output logic              ram_dq_oe,
  input  logic [31:0]       ram_dq_i,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam logic [2:0] c_s_idle    = 3'd0;
  localparam logic [2:0] c_s_f_rd    = 3'd1;
  localparam logic [2:0] c_s_d_rd    = 3'd2;
  localparam logic [2:0] c_s_w_setup = 3'd3;
  localparam logic [2:0] c_s_w_pulse = 3'd4;
  localparam logic [2:0] c_s_w_hold  = 3'd5;
  localparam logic [2:0] c_s_done    = 3'd6;

  localparam logic [1:0] c_op_fetch  = 2'd0;
  localparam logic [1:0] c_op_load   = 2'd1;
  localparam logic [1:0] c_op_store  = 2'd2;

  localparam logic [2:0] c_rd_last   = 3'(RD_WAIT - 1);
  localparam logic [2:0] c_we_last   = 3'(WE_WIDTH - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [2:0]        r_cnt;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_lane;
  logic              r_byte;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be_n;
  logic [31:0]       r_if_data;
  logic [31:0]       r_mem_rdata;

  logic              w_dreq;
  logic              w_accept;
  logic              w_rd_last;
  logic [7:0]        w_lane_byte;
  logic [31:0]       w_load_fmt;
  logic              w_if_valid;
  logic              w_mem_done;
  logic              w_unused;

  // Byte-offset and upper address bits have no SRAM pin to go to.
  assign w_unused = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2]};

  assign w_dreq    = mem_read | mem_write;
  assign w_accept  = (r_state == c_s_idle) && (w_state_nxt != c_s_idle);
  assign w_rd_last = (r_cnt == c_rd_last);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_s_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_s_idle: begin
        // Data side has fixed priority; read+write together is a write.
        if (w_dreq) begin
          w_state_nxt = mem_write ? c_s_w_setup : c_s_d_rd;
        end else if (if_req) begin
          w_state_nxt = c_s_f_rd;
        end
      end
      c_s_f_rd,
      c_s_d_rd: begin
        if (w_rd_last) w_state_nxt = c_s_done;
      end
      c_s_w_setup: w_state_nxt = c_s_w_pulse;
      c_s_w_pulse: begin
        if (r_cnt == c_we_last) w_state_nxt = c_s_w_hold;
      end
      c_s_w_hold:  w_state_nxt = c_s_done;
      c_s_done:    w_state_nxt = c_s_idle;
      default:     w_state_nxt = c_s_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (strobes and pulses decoded from state)
  // --------------------------------------------------------------------------
  always_comb begin
    ram_ce_n   = 1'b1;
    ram_oe_n   = 1'b1;
    ram_we_n   = 1'b1;
    ram_be_n   = 4'hF;
    ram_dq_oe  = 1'b0;
    w_if_valid = 1'b0;
    w_mem_done = 1'b0;
    case (r_state)
      c_s_f_rd,
      c_s_d_rd: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
        ram_be_n = 4'h0;
      end
      c_s_w_setup,
      c_s_w_hold: begin
        ram_ce_n  = 1'b0;
        ram_be_n  = r_be_n;
        ram_dq_oe = 1'b1;
      end
      c_s_w_pulse: begin
        ram_ce_n  = 1'b0;
        ram_we_n  = 1'b0;
        ram_be_n  = r_be_n;
        ram_dq_oe = 1'b1;
      end
      c_s_done: begin
        w_if_valid = (r_op == c_op_fetch);
        w_mem_done = (r_op != c_op_fetch);
      end
      default: begin
      end
    endcase
  end

  assign if_valid  = w_if_valid;
  assign mem_done  = w_mem_done;
  // Stalls follow the live request so the pipeline freezes from the very
  // first cycle it asks; reset forces them low.
  assign if_stall  = rst & if_req & ~w_if_valid;
  assign mem_stall = rst & w_dreq & ~w_mem_done;

  assign ram_addr  = r_addr;
  assign ram_dq_o  = r_wdata;
  assign if_data   = r_if_data;
  assign mem_rdata = r_mem_rdata;

  // --------------------------------------------------------------------------
  // Wait/pulse counter: restarts on every state change
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 3'd0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= 3'd0;
    end else begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Request latch: captured once at acceptance, frozen for the access
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= c_op_fetch;
      r_addr  <= '0;
      r_lane  <= 2'd0;
      r_byte  <= 1'b0;
      r_wdata <= 32'd0;
      r_be_n  <= 4'hF;
    end else if (w_accept) begin
      if (w_dreq) begin
        r_op   <= mem_write ? c_op_store : c_op_load;
        r_addr <= mem_addr[ADDR_W+1:2];
        r_lane <= mem_addr[1:0];
        r_byte <= load_byte;
        if (mem_write) begin
          // Byte stores replicate the byte on every lane; be_n picks one.
          r_wdata <= load_byte ? {4{mem_wdata[7:0]}} : mem_wdata;
          r_be_n  <= load_byte ? ~(4'b0001 << mem_addr[1:0]) : 4'h0;
        end
      end else begin
        r_op   <= c_op_fetch;
        r_addr <= if_addr[ADDR_W+1:2];
        r_lane <= 2'd0;
        r_byte <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Load formatting: LB picks the addressed lane and sign-extends it
  // --------------------------------------------------------------------------
  always_comb begin
    case (r_lane)
      2'd0:    w_lane_byte = ram_dq_i[7:0];
      2'd1:    w_lane_byte = ram_dq_i[15:8];
      2'd2:    w_lane_byte = ram_dq_i[23:16];
      default: w_lane_byte = ram_dq_i[31:24];
    endcase
    w_load_fmt = r_byte ? {{24{w_lane_byte[7]}}, w_lane_byte} : ram_dq_i;
  end

  // --------------------------------------------------------------------------
  // Read capture on the last oe_n-low cycle; values hold until overwritten
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      if ((r_state == c_s_f_rd) && w_rd_last) r_if_data   <= ram_dq_i;
      if ((r_state == c_s_d_rd) && w_rd_last) r_mem_rdata <= w_load_fmt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Self-checking bench for sram_port_arbiter (RD_WAIT=1,
//            WE_WIDTH=2): table of single accesses, arbitration sequence,
//            reset checks. Expected pulses are queued at drive time and
//            popped when if_valid/mem_done appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

  localparam int AW  = 20;
  localparam int RDW = 1;
  localparam int WEW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic [31:0]   if_data;
  logic          if_valid;
  logic          if_stall;
  logic          mem_read;
  logic          mem_write;
  logic          load_byte;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_done;
  logic          mem_stall;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_dq_o;
  logic          ram_dq_oe;
  logic [31:0]   ram_dq_i;
  logic [3:0]    ram_be_n;
  logic          ram_ce_n;
  logic          ram_oe_n;
  logic          ram_we_n;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(AW), .RD_WAIT(RDW), .WE_WIDTH(WEW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data),
    .if_valid(if_valid), .if_stall(if_stall),
    .mem_read(mem_read), .mem_write(mem_write), .load_byte(load_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_stall(mem_stall),
    .ram_addr(ram_addr), .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe),
    .ram_dq_i(ram_dq_i), .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // kind: 0 fetch, 1 load, 2 store
  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          kind;
    bit          both;
    bit          perturb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lb;
    logic [31:0] sram;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_dq;
  } vec_t;

  function automatic vec_t mk(input int kind, input bit both, input bit perturb,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic lb, input logic [31:0] sram,
                              input logic [31:0] exp_data, input logic [3:0] exp_be,
                              input logic [31:0] exp_dq);
    vec_t v;
    v.kind = kind; v.both = both; v.perturb = perturb; v.addr = addr;
    v.wdata = wdata; v.lb = lb; v.sram = sram; v.exp_data = exp_data;
    v.exp_be = exp_be; v.exp_dq = exp_dq;
    return v;
  endfunction

  task automatic push_exp(input int kind, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_pulse: got if_valid=%0b mem_done=%0b expected no pulse",
               tag, if_valid, mem_done);
    end else begin
      e = sb.pop_front();
      chk({tag, "_if_valid"}, {31'd0, if_valid}, {31'd0, e.kind == 0});
      chk({tag, "_mem_done"}, {31'd0, mem_done}, {31'd0, e.kind != 0});
      if (e.kind == 0) chk({tag, "_if_data"}, if_data, e.data);
      if (e.kind == 1) chk({tag, "_mem_rdata"}, mem_rdata, e.data);
    end
  endtask

  task automatic drop_reqs();
    if_req    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [AW-1:0] exp_addr;
    int lat, oe_cnt, we_cnt;
    bit addr_bad, be_bad, dq_bad, cont_bad, stall_bad, setup_bad, pulse, st;
    exp_addr = v.addr[AW+1:2];
    lat = 0; oe_cnt = 0; we_cnt = 0;
    addr_bad = 0; be_bad = 0; dq_bad = 0; cont_bad = 0; stall_bad = 0; setup_bad = 0;
    @(negedge clk);
    if (v.kind == 0) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      mem_read  = (v.kind == 1) || v.both;
      mem_write = (v.kind == 2);
      load_byte = v.lb;
      mem_addr  = v.addr;
      mem_wdata = v.wdata;
    end
    ram_dq_i = v.sram;
    push_exp(v.kind, v.exp_data);
    #1;
    st = (v.kind == 0) ? if_stall : mem_stall;
    if (!st) stall_bad = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      pulse = if_valid | mem_done;
      st    = (v.kind == 0) ? if_stall : mem_stall;
      if (!ram_oe_n) oe_cnt++;
      if (!ram_we_n) we_cnt++;
      if (!ram_oe_n && ram_dq_oe) cont_bad = 1;
      if (!ram_ce_n) begin
        if (ram_addr !== exp_addr) addr_bad = 1;
        if (ram_be_n !== v.exp_be) be_bad = 1;
      end
      if (!ram_we_n && (ram_dq_o !== v.exp_dq)) dq_bad = 1;
      if (v.kind == 2 && c == 1 &&
          (ram_dq_oe !== 1'b1 || ram_we_n !== 1'b1 || ram_ce_n !== 1'b0)) setup_bad = 1;
      if (pulse == st) stall_bad = 1;
      if (pulse) begin
        lat = c;
        pop_check(tag);
        drop_reqs();
        break;
      end
      if (v.perturb && c == 2) begin
        mem_addr  = ~v.addr;
        mem_wdata = ~v.wdata;
        load_byte = ~v.lb;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no pulse in 20 cycles expected one", tag);
      drop_reqs();
      void'(sb.pop_back());
    end else begin
      chk({tag, "_latency"}, lat, (v.kind == 2) ? WEW + 3 : RDW + 1);
    end
    chk({tag, "_ram_addr"},  {31'd0, addr_bad},  32'd0);
    chk({tag, "_be_n"},      {31'd0, be_bad},    32'd0);
    chk({tag, "_contention"},{31'd0, cont_bad},  32'd0);
    chk({tag, "_stall"},     {31'd0, stall_bad}, 32'd0);
    chk({tag, "_oe_cycles"}, oe_cnt, (v.kind == 2) ? 0 : RDW);
    chk({tag, "_we_cycles"}, we_cnt, (v.kind == 2) ? WEW : 0);
    if (v.kind == 2) begin
      chk({tag, "_dq_o"},  {31'd0, dq_bad},    32'd0);
      chk({tag, "_setup"}, {31'd0, setup_bad}, 32'd0);
    end
  endtask

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_d, c_f;
    bit stall_bad, seen_pulse, fetch_addr_bad;

    tbl[0]  = mk(0, 0, 0, 32'h8000_0004, 32'h0,         0, 32'h3C01_ABCD, 32'h3C01_ABCD, 4'h0,    32'h0);
    tbl[1]  = mk(1, 0, 0, 32'h8000_0100, 32'h0,         0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'h0,    32'h0);
    tbl[2]  = mk(1, 0, 0, 32'h8000_0103, 32'h0,         1, 32'h80FF_1234, 32'hFFFF_FF80, 4'h0,    32'h0);
    tbl[3]  = mk(1, 0, 0, 32'h8000_0101, 32'h0,         1, 32'h80FF_1234, 32'h0000_0012, 4'h0,    32'h0);
    tbl[4]  = mk(1, 0, 0, 32'h8000_0102, 32'h0,         1, 32'h80FF_1234, 32'hFFFF_FFFF, 4'h0,    32'h0);
    tbl[5]  = mk(1, 0, 0, 32'h8000_0100, 32'h0,         1, 32'h80FF_1234, 32'h0000_0034, 4'h0,    32'h0);
    tbl[6]  = mk(2, 0, 0, 32'h8000_0202, 32'h0000_00A5, 1, 32'h0,         32'h0,         4'b1011, 32'hA5A5_A5A5);
    tbl[7]  = mk(2, 0, 1, 32'h8000_0204, 32'hCAFE_F00D, 0, 32'h0,         32'h0,         4'b0000, 32'hCAFE_F00D);
    tbl[8]  = mk(2, 1, 0, 32'h8000_0208, 32'h0102_0304, 0, 32'h0,         32'h0,         4'b0000, 32'h0102_0304);
    tbl[9]  = mk(2, 0, 0, 32'h8000_0001, 32'hFFFF_FF3C, 1, 32'h0,         32'h0,         4'b1101, 32'h3C3C_3C3C);
    tbl[10] = mk(0, 0, 0, 32'h8000_FFFE, 32'h0,         0, 32'h1234_5678, 32'h1234_5678, 4'h0,    32'h0);

    // Reset state, with requests up to show stalls are held low in reset
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    mem_read = 1'b1; mem_write = 1'b0; load_byte = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; ram_dq_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ce_n",      {31'd0, ram_ce_n},  32'd1);
    chk("rst_oe_n",      {31'd0, ram_oe_n},  32'd1);
    chk("rst_we_n",      {31'd0, ram_we_n},  32'd1);
    chk("rst_be_n",      {28'd0, ram_be_n},  32'hF);
    chk("rst_dq_oe",     {31'd0, ram_dq_oe}, 32'd0);
    chk("rst_ram_addr",  {12'd0, ram_addr},  32'd0);
    chk("rst_dq_o",      ram_dq_o,           32'd0);
    chk("rst_if_data",   if_data,            32'd0);
    chk("rst_mem_rdata", mem_rdata,          32'd0);
    chk("rst_pulses",    {30'd0, if_valid, mem_done}, 32'd0);
    chk("rst_stalls",    {30'd0, if_stall, mem_stall}, 32'd0);
    drop_reqs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i], $sformatf("v%0d", i));
    end

    // Fetch and load requested together: load first, then the fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8000_0008;
    mem_read = 1'b1; mem_write = 1'b0; load_byte = 1'b0; mem_addr = 32'h8000_0100;
    ram_dq_i = 32'h1111_2222;
    push_exp(1, 32'h1111_2222);
    push_exp(0, 32'h3333_4444);
    c_d = 0; c_f = 0; stall_bad = 0; fetch_addr_bad = 0;
    #1;
    if (!if_stall) stall_bad = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) chk("arb_first_addr", {12'd0, ram_addr}, 32'h0000_0040);
      if (!ram_oe_n && c_d != 0 && ram_addr !== 20'h00002) fetch_addr_bad = 1;
      if (!if_valid && !if_stall) stall_bad = 1;
      if (mem_done) begin
        c_d = c;
        pop_check("arb_data");
        mem_read = 1'b0;
        ram_dq_i = 32'h3333_4444;
      end
      if (if_valid) begin
        c_f = c;
        pop_check("arb_fetch");
        if_req = 1'b0;
        break;
      end
    end
    drop_reqs();
    chk("arb_data_cycle",  c_d, RDW + 1);
    chk("arb_fetch_cycle", c_f, 2 * (RDW + 1) + 1);
    chk("arb_if_stall",    {31'd0, stall_bad},      32'd0);
    chk("arb_fetch_addr",  {31'd0, fetch_addr_bad}, 32'd0);
    while (sb.size() != 0) void'(sb.pop_front());

    // Reset in the middle of a write pulse
    @(negedge clk);
    mem_write = 1'b1; mem_read = 1'b0; load_byte = 1'b0;
    mem_addr = 32'h8000_0300; mem_wdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    chk("mid_pre_we_n", {31'd0, ram_we_n}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid_we_n",      {31'd0, ram_we_n},  32'd1);
    chk("mid_dq_oe",     {31'd0, ram_dq_oe}, 32'd0);
    chk("mid_ce_n",      {31'd0, ram_ce_n},  32'd1);
    chk("mid_be_n",      {28'd0, ram_be_n},  32'hF);
    chk("mid_ram_addr",  {12'd0, ram_addr},  32'd0);
    chk("mid_mem_rdata", mem_rdata,          32'd0);
    chk("mid_mem_stall", {31'd0, mem_stall}, 32'd0);
    drop_reqs();
    @(negedge clk);
    rst = 1'b1;
    seen_pulse = 0;
    repeat (10) begin
      @(negedge clk);
      if (if_valid || mem_done || !ram_ce_n) seen_pulse = 1;
    end
    chk("mid_no_done", {31'd0, seen_pulse}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
